// File: rtl/ro_measure_sequencer.sv
// Sequences one ring-oscillator aging measurement: stress, settle, clear, gate, capture.
// Single-shot on start, or back-to-back while auto_run is held high.
module ro_measure_sequencer #(
    parameter int STRESS_CYCLES = 1000,
    parameter int SETTLE_CYCLES = 16,
    parameter int GATE_CYCLES   = 1000000,
    parameter int CAPTURE_DLY   = 3,
    parameter int TW            = 32
) (
    input  logic        fpga_clk1,
    input  logic        reset,
    input  logic        start,
    input  logic        auto_run,
    input  logic        mode_sel,
    input  logic [15:0] cnt_value,
    output logic        ro_mode,
    output logic        ro_stress,
    output logic        cnt_clear,
    output logic        cnt_en,
    output logic [15:0] value_out,
    output logic        value_valid,
    output logic        busy,
    output logic [7:0]  run_count,
    output logic [2:0]  dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STRESS = 3'd1,
        SETTLE = 3'd2,
        CLEAR  = 3'd3,
        GATE   = 3'd4,
        HOLD   = 3'd5,
        DONE   = 3'd6
    } state_e;

    localparam logic [TW-1:0] ONE_T    = TW'(1);
    localparam logic [TW-1:0] STRESS_T = TW'(STRESS_CYCLES);
    localparam logic [TW-1:0] SETTLE_T = TW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] GATE_T   = TW'(GATE_CYCLES);
    localparam logic [TW-1:0] DLY_T    = TW'(CAPTURE_DLY);

    // A zero-length stress phase means every run begins directly in SETTLE.
    localparam state_e        FIRST_S  = (STRESS_CYCLES == 0) ? SETTLE : STRESS;
    localparam logic [TW-1:0] FIRST_T  = (STRESS_CYCLES == 0) ? SETTLE_T : STRESS_T;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          mode_q, mode_d;
    logic          capture;

    logic          ro_mode_q, ro_stress_q, cnt_clear_q, cnt_en_q;
    logic          value_valid_q, busy_q;
    logic [15:0]   value_out_q;
    logic [7:0]    run_count_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        mode_d  = mode_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (start) begin
                    mode_d  = mode_sel;
                    state_d = FIRST_S;
                    timer_d = FIRST_T;
                end
            end
            STRESS: begin
                timer_d = timer_q - ONE_T;
                if (timer_q == ONE_T) begin
                    state_d = SETTLE;
                    timer_d = SETTLE_T;
                end
            end
            SETTLE: begin
                timer_d = timer_q - ONE_T;
                if (timer_q == ONE_T) begin
                    state_d = CLEAR;
                    timer_d = '0;
                end
            end
            CLEAR: begin
                state_d = GATE;
                timer_d = GATE_T;
            end
            GATE: begin
                timer_d = timer_q - ONE_T;
                if (timer_q == ONE_T) begin
                    state_d = HOLD;
                    timer_d = DLY_T;
                end
            end
            HOLD: begin
                timer_d = timer_q - ONE_T;
                if (timer_q == ONE_T) begin
                    state_d = DONE;
                    timer_d = '0;
                    capture = 1'b1;
                end
            end
            DONE: begin
                // start is ignored here; only auto_run can restart from DONE.
                if (auto_run) begin
                    mode_d  = mode_sel;
                    state_d = FIRST_S;
                    timer_d = FIRST_T;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge fpga_clk1) begin
        if (reset) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            mode_q        <= 1'b0;
            ro_mode_q     <= 1'b0;
            ro_stress_q   <= 1'b0;
            cnt_clear_q   <= 1'b0;
            cnt_en_q      <= 1'b0;
            value_out_q   <= '0;
            value_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            run_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            mode_q        <= mode_d;
            ro_stress_q   <= (state_d == STRESS);
            ro_mode_q     <= mode_d && (state_d inside {SETTLE, CLEAR, GATE, HOLD});
            cnt_clear_q   <= (state_d == CLEAR);
            cnt_en_q      <= (state_d == GATE);
            value_valid_q <= (state_d == DONE);
            busy_q        <= (state_d != IDLE);
            if (capture) begin
                value_out_q <= cnt_value;
            end
            if (state_d == DONE) begin
                run_count_q <= run_count_q + 8'd1;
            end
        end
    end

    assign ro_mode     = ro_mode_q;
    assign ro_stress   = ro_stress_q;
    assign cnt_clear   = cnt_clear_q;
    assign cnt_en      = cnt_en_q;
    assign value_out   = value_out_q;
    assign value_valid = value_valid_q;
    assign busy        = busy_q;
    assign run_count   = run_count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ro_measure_sequencer.sv
// Bench for ro_measure_sequencer: a stressed build and a zero-stress build share stimulus.
// Cycle traces come from a phase table; captured counts go through a scoreboard queue.
module tb_ro_measure_sequencer;

    localparam int S_A  = 4;
    localparam int S_B  = 0;
    localparam int SET  = 2;
    localparam int GT   = 8;
    localparam int DLY  = 3;
    localparam int NVEC = 21;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, auto_a, auto_b, mode_sel;
    logic [15:0] cnt_value;

    logic        a_ro_mode, a_ro_stress, a_cnt_clear, a_cnt_en, a_value_valid, a_busy;
    logic [15:0] a_value_out;
    logic [7:0]  a_run_count;
    logic [2:0]  a_state;
    logic        b_ro_mode, b_ro_stress, b_cnt_clear, b_cnt_en, b_value_valid, b_busy;
    logic [15:0] b_value_out;
    logic [7:0]  b_run_count;
    logic [2:0]  b_state;

    int vec_n = 0;
    int err_n = 0;
    int valid_a_n = 0;
    int valid_b_n = 0;

    logic [15:0] exp_a_q[$];
    logic [15:0] exp_b_q[$];

    typedef struct {
        logic        start;
        logic        mode_sel;
        logic [15:0] cnt;
        logic [5:0]  exp_a;
        logic [5:0]  exp_b;
    } vec_t;

    vec_t tbl[NVEC];

    ro_measure_sequencer #(
        .STRESS_CYCLES(S_A), .SETTLE_CYCLES(SET), .GATE_CYCLES(GT), .CAPTURE_DLY(DLY), .TW(32)
    ) u_dut_a (
        .fpga_clk1(clk), .reset(rst), .start(start), .auto_run(auto_a), .mode_sel(mode_sel),
        .cnt_value(cnt_value), .ro_mode(a_ro_mode), .ro_stress(a_ro_stress),
        .cnt_clear(a_cnt_clear), .cnt_en(a_cnt_en), .value_out(a_value_out),
        .value_valid(a_value_valid), .busy(a_busy), .run_count(a_run_count),
        .dbg_state_o(a_state)
    );

    ro_measure_sequencer #(
        .STRESS_CYCLES(S_B), .SETTLE_CYCLES(SET), .GATE_CYCLES(GT), .CAPTURE_DLY(DLY), .TW(32)
    ) u_dut_b (
        .fpga_clk1(clk), .reset(rst), .start(start), .auto_run(auto_b), .mode_sel(mode_sel),
        .cnt_value(cnt_value), .ro_mode(b_ro_mode), .ro_stress(b_ro_stress),
        .cnt_clear(b_cnt_clear), .cnt_en(b_cnt_en), .value_out(b_value_out),
        .value_valid(b_value_valid), .busy(b_busy), .run_count(b_run_count),
        .dbg_state_o(b_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_n++;
        if (act !== exp) begin
            err_n++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Expected {ro_stress, ro_mode, cnt_clear, cnt_en, value_valid, busy} k cycles after start.
    function automatic logic [5:0] phase_exp(int k, int s, logic m);
        int clr_k, done_k;
        clr_k  = s + SET + 1;
        done_k = clr_k + GT + DLY + 1;
        phase_exp = {(k >= 1 && k <= s),
                     m && (k >= s + 1 && k < done_k),
                     (k == clr_k),
                     (k > clr_k && k <= clr_k + GT),
                     (k == done_k),
                     (k >= 1 && k <= done_k)};
    endfunction

    // Scoreboard consumer plus per-cycle invariants.
    always @(negedge clk) begin
        if (!rst) begin
            check("excl_a", {31'd0, a_ro_stress & a_cnt_en}, 32'd0);
            check("b_stress", {31'd0, b_ro_stress}, 32'd0);
            if (a_value_valid) begin
                valid_a_n++;
                if (exp_a_q.size() == 0) check("a_unexpected_valid", 32'd1, 32'd0);
                else check("a_value_out", {16'd0, a_value_out}, {16'd0, exp_a_q.pop_front()});
            end
            if (b_value_valid) begin
                valid_b_n++;
                if (exp_b_q.size() == 0) check("b_unexpected_valid", 32'd1, 32'd0);
                else check("b_value_out", {16'd0, b_value_out}, {16'd0, exp_b_q.pop_front()});
            end
        end
    end

    initial begin
        int v0;
        rst = 1'b1; start = 1'b0; auto_a = 1'b0; auto_b = 1'b0; mode_sel = 1'b0;
        cnt_value = 16'h0;

        for (int k = 0; k < NVEC; k++) begin
            tbl[k].start    = (k == 0);
            tbl[k].mode_sel = 1'b1;
            tbl[k].cnt      = 16'h1234;
            tbl[k].exp_a    = phase_exp(k, S_A, 1'b1);
            tbl[k].exp_b    = phase_exp(k, S_B, 1'b1);
        end

        @(negedge clk);
        do_reset();
        check("rst_a_outs", {26'd0, a_ro_stress, a_ro_mode, a_cnt_clear, a_cnt_en, a_value_valid, a_busy}, 32'd0);
        check("rst_a_value", {16'd0, a_value_out}, 32'd0);
        check("rst_a_runs", {24'd0, a_run_count}, 32'd0);
        check("rst_b_outs", {26'd0, b_ro_stress, b_ro_mode, b_cnt_clear, b_cnt_en, b_value_valid, b_busy}, 32'd0);

        // Single run with mode_sel=1, traced cycle by cycle.
        exp_a_q.push_back(16'h1234);
        exp_b_q.push_back(16'h1234);
        for (int k = 0; k < NVEC; k++) begin
            check($sformatf("trace_a[%0d]", k),
                  {26'd0, a_ro_stress, a_ro_mode, a_cnt_clear, a_cnt_en, a_value_valid, a_busy},
                  {26'd0, tbl[k].exp_a});
            check($sformatf("trace_b[%0d]", k),
                  {26'd0, b_ro_stress, b_ro_mode, b_cnt_clear, b_cnt_en, b_value_valid, b_busy},
                  {26'd0, tbl[k].exp_b});
            start     = tbl[k].start;
            mode_sel  = tbl[k].mode_sel;
            cnt_value = tbl[k].cnt;
            step();
        end
        check("run1_a_count", {24'd0, a_run_count}, 32'd1);
        check("run1_b_count", {24'd0, b_run_count}, 32'd1);
        check("run1_a_value", {16'd0, a_value_out}, 32'h1234);

        // Reset in the middle of the gate window aborts the run.
        start = 1'b1; cnt_value = 16'h5555;
        step();
        start = 1'b0;
        for (int k = 1; k < 10; k++) step();
        check("pre_rst_cnt_en", {31'd0, a_cnt_en}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_cnt_en", {31'd0, a_cnt_en}, 32'd0);
        check("mid_rst_busy", {31'd0, a_busy}, 32'd0);
        check("mid_rst_value", {16'd0, a_value_out}, 32'd0);
        check("mid_rst_runs", {24'd0, a_run_count}, 32'd0);
        check("mid_rst_b_busy", {31'd0, b_busy}, 32'd0);

        // Extra start pulses while busy are dropped; mode_sel changes mid-run are ignored.
        v0 = valid_a_n;
        exp_a_q.push_back(16'hBEEF);
        exp_b_q.push_back(16'hBEEF);
        for (int k = 0; k <= 40; k++) begin
            if (k == 6 || k == 10) check($sformatf("a_mode_held[%0d]", k), {31'd0, a_ro_mode}, 32'd0);
            if (k == 2) check("b_mode_held", {31'd0, b_ro_mode}, 32'd0);
            if (k == 10) check("a_in_gate", {31'd0, a_cnt_en}, 32'd1);
            start     = (k == 0 || k == 9 || k == 11 || k == 13);
            mode_sel  = (k >= 1);
            cnt_value = 16'hBEEF;
            step();
        end
        check("drop_a_valids", valid_a_n - v0, 32'd1);
        check("drop_a_runs", {24'd0, a_run_count}, 32'd1);
        check("drop_b_runs", {24'd0, b_run_count}, 32'd1);
        check("drop_a_idle", {31'd0, a_busy}, 32'd0);

        // Back-to-back runs under auto_run, dropped partway through the third run.
        do_reset();
        mode_sel = 1'b0;
        exp_a_q.push_back(16'h1000);
        exp_a_q.push_back(16'h1001);
        exp_a_q.push_back(16'h1002);
        exp_b_q.push_back(16'h1000);
        for (int k = 0; k <= 65; k++) begin
            check($sformatf("auto_valid[%0d]", k), {31'd0, a_value_valid},
                  {31'd0, (k == 19 || k == 38 || k == 57)});
            if (k == 58) check("auto_idle", {31'd0, a_busy}, 32'd0);
            start     = (k == 0);
            auto_a    = (k < 45);
            cnt_value = (k < 19) ? 16'h1000 : (k < 38) ? 16'h1001 : 16'h1002;
            step();
        end
        check("auto_a_runs", {24'd0, a_run_count}, 32'd3);
        check("auto_b_runs", {24'd0, b_run_count}, 32'd1);
        check("sb_a_empty", exp_a_q.size(), 32'd0);
        check("sb_b_empty", exp_b_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
        $finish;
    end

endmodule
